data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 103 ++++++++++
 tb/tb_data_mem_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder for a pipelined core's MEM stage.
// Stalls the pipeline for LATENCY cycles per access and then completes the access in a one-cycle DONE state.
module data_mem_responder #(
   parameter int ADDR_WIDTH = 6,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_ren,
   input  logic        mem_wen,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_dout,
   output logic [31:0] mem_din,
   output logic        mem_stall,
   output logic        mem_err
);

   localparam int         DEPTH    = 1 << ADDR_WIDTH;
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                  state;
   logic [3:0]              cnt;
   logic                    lat_wr;
   logic [31:0]             lat_addr;
   logic [31:0]             lat_data;
   logic [31:0]             ram [DEPTH];

   logic                    one_op;
   logic                    aligned;
   logic                    req_ok;
   logic                    req_bad;
   logic                    finish;
   logic                    acc_wr;
   logic [31:0]             acc_addr;
   logic [31:0]             acc_data;
   logic                    acc_oor;
   logic [ADDR_WIDTH-1:0]   acc_idx;

   // Requests are qualified by rst_n so nothing stalls or completes while reset is held.
   always_comb begin
      one_op   = mem_ren ^ mem_wen;
      aligned  = (mem_addr[1:0] == 2'b00);
      req_ok   = rst_n && (state == IDLE) && one_op && aligned;
      req_bad  = rst_n && (state == IDLE) && (mem_ren || mem_wen) && !(one_op && aligned);
      finish   = (req_ok && (LATENCY == 1)) || (rst_n && (state == BUSY) && (cnt == 4'd1));
      mem_stall = req_ok || (state == BUSY);
   end

   // With LATENCY==1 the access completes on the same edge that would latch it, so use live inputs.
   always_comb begin
      acc_wr   = (state == IDLE) ? mem_wen  : lat_wr;
      acc_addr = (state == IDLE) ? mem_addr : lat_addr;
      acc_data = (state == IDLE) ? mem_dout : lat_data;
      acc_oor  = (acc_addr >> (ADDR_WIDTH + 2)) != 32'd0;
      acc_idx  = acc_addr[ADDR_WIDTH+1:2];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         lat_wr   <= 1'b0;
         lat_addr <= 32'd0;
         lat_data <= 32'd0;
         mem_din  <= 32'd0;
         mem_err  <= 1'b0;
      end else begin
         mem_err <= req_bad;
         if (finish && !acc_wr) begin
            mem_din <= acc_oor ? 32'd0 : ram[acc_idx];
         end
         case (state)
            IDLE: begin
               if (req_ok) begin
                  lat_wr   <= mem_wen;
                  lat_addr <= mem_addr;
                  lat_data <= mem_dout;
                  cnt      <= CNT_LOAD;
                  state    <= (LATENCY == 1) ? DONE : BUSY;
               end
            end
            BUSY: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Storage is deliberately outside the reset domain so contents survive rst_n.
   always_ff @(posedge clk) begin
      if (finish && acc_wr && !acc_oor) begin
         ram[acc_idx] <= acc_data;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance at LATENCY=2, one at LATENCY=1, both ADDR_WIDTH=6.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        ren   [2];
   logic        wen   [2];
   logic [31:0] addr  [2];
   logic [31:0] dout  [2];
   logic [31:0] din   [2];
   logic        stall [2];
   logic        err   [2];

   logic [31:0] mdl [2][64];
   logic [31:0] last_din [2];
   logic [31:0] exp_q [$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   data_mem_responder #(.ADDR_WIDTH(6), .LATENCY(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .mem_ren(ren[0]), .mem_wen(wen[0]), .mem_addr(addr[0]),
      .mem_dout(dout[0]), .mem_din(din[0]), .mem_stall(stall[0]), .mem_err(err[0]));

   data_mem_responder #(.ADDR_WIDTH(6), .LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .mem_ren(ren[1]), .mem_wen(wen[1]), .mem_addr(addr[1]),
      .mem_dout(dout[1]), .mem_din(din[1]), .mem_stall(stall[1]), .mem_err(err[1]));

   // Called at a negedge with the DUT in IDLE; returns at the negedge of the IDLE cycle after DONE.
   task automatic access(input int s, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input bit scramble, output int done_cyc);
      int          lat = (s == 0) ? 2 : 1;
      int          n = 0;
      logic        oor = (a >> 8) != 32'd0;
      logic [31:0] want;
      ren[s] = r; wen[s] = w; addr[s] = a; dout[s] = d;
      if (r) exp_q.push_back(oor ? 32'd0 : mdl[s][a[7:2]]);
      else   exp_q.push_back(last_din[s]);
      if (w && !oor) mdl[s][a[7:2]] = d;
      #1;
      while (stall[s] === 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
         if (scramble) begin
            ren[s] = 1'($urandom_range(0, 1)); wen[s] = 1'($urandom_range(0, 1));
            addr[s] = $urandom; dout[s] = $urandom;
         end else begin
            ren[s] = 1'b0; wen[s] = 1'b0;
         end
         #1;
      end
      ren[s] = 1'b0; wen[s] = 1'b0;
      done_cyc = cyc;
      total++;
      if (n != lat) begin
         bad++; $display("FAIL stall_len s=%0d addr=%h got=%0d want=%0d", s, a, n, lat);
      end
      total++;
      if (err[s] !== 1'b0) begin
         bad++; $display("FAIL err_on_access s=%0d addr=%h got=%b want=0", s, a, err[s]);
      end
      want = exp_q.pop_front();
      total++;
      if (din[s] !== want) begin
         bad++; $display("FAIL din s=%0d addr=%h r=%b got=%h want=%h", s, a, r, din[s], want);
      end
      last_din[s] = want;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      for (int s = 0; s < 2; s++) begin
         total++;
         if (din[s] !== 32'd0 || stall[s] !== 1'b0 || err[s] !== 1'b0) begin
            bad++; $display("FAIL reset_state s=%0d got=%h/%b/%b want=0/0/0", s, din[s], stall[s], err[s]);
         end
         last_din[s] = 32'd0;
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_fill();
      int dc;
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < 64; i++)
            access(s, 1'b0, 1'b1, 32'(i * 4), 32'hC0DE0000 | 32'(i * 17 + s), 1'b0, dc);
   endtask

   task automatic test_write_read();
      int dc;
      access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, dc);
      access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, dc);
      access(0, 1'b1, 1'b0, 32'hFC, 32'h0, 1'b0, dc);
   endtask

   task automatic test_back_to_back();
      int d0, d1;
      access(1, 1'b0, 1'b1, 32'h4, 32'h1, 1'b0, d0);
      access(1, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, d1);
      total++;
      if (d1 - d0 != 2) begin
         bad++; $display("FAIL b2b_gap got=%0d want=2", d1 - d0);
      end
      access(1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, d0);
   endtask

   task automatic test_reject();
      int          dc;
      logic [31:0] ra [2] = '{32'h3, 32'h8};
      for (int k = 0; k < 2; k++) begin
         ren[0] = 1'b1; wen[0] = (k == 1); addr[0] = ra[k]; dout[0] = 32'hBAD0BAD0;
         #1;
         total++;
         if (stall[0] !== 1'b0 || err[0] !== 1'b0) begin
            bad++; $display("FAIL reject_cycle_t k=%0d got=%b/%b want=0/0", k, stall[0], err[0]);
         end
         @(negedge clk); ren[0] = 1'b0; wen[0] = 1'b0; #1;
         total++;
         if (err[0] !== 1'b1 || stall[0] !== 1'b0) begin
            bad++; $display("FAIL reject_err_pulse k=%0d got=%b/%b want=1/0", k, err[0], stall[0]);
         end
         @(negedge clk); #1;
         total++;
         if (err[0] !== 1'b0) begin
            bad++; $display("FAIL reject_err_clear k=%0d got=%b want=0", k, err[0]);
         end
         @(negedge clk);
      end
      access(0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, dc);
   endtask

   task automatic test_out_of_range();
      int dc;
      access(0, 1'b0, 1'b1, 32'h1000, 32'h55, 1'b0, dc);
      access(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, dc);
      access(0, 1'b1, 1'b0, 32'h1000, 32'h0, 1'b0, dc);
   endtask

   task automatic test_hold();
      logic exp_stall [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [31:0] want;
      ren[0] = 1'b1; wen[0] = 1'b0; addr[0] = 32'h10;
      exp_q.push_back(mdl[0][4]);
      exp_q.push_back(mdl[0][4]);
      for (int i = 0; i < 5; i++) begin
         #1;
         total++;
         if (stall[0] !== exp_stall[i]) begin
            bad++; $display("FAIL hold_stall i=%0d got=%b want=%b", i, stall[0], exp_stall[i]);
         end
         if (i == 2) begin
            want = exp_q.pop_front();
            total++;
            if (din[0] !== want) begin
               bad++; $display("FAIL hold_din1 got=%h want=%h", din[0], want);
            end
         end
         @(negedge clk);
         if (i == 4) ren[0] = 1'b0;
      end
      #1;
      want = exp_q.pop_front();
      total++;
      if (din[0] !== want || stall[0] !== 1'b0) begin
         bad++; $display("FAIL hold_din2 got=%h/%b want=%h/0", din[0], stall[0], want);
      end
      last_din[0] = want;
      @(negedge clk);
   endtask

   task automatic test_scramble();
      int dc;
      access(0, 1'b0, 1'b1, 32'h24, 32'h12345678, 1'b1, dc);
      access(0, 1'b1, 1'b0, 32'h24, 32'h0, 1'b1, dc);
      access(0, 1'b1, 1'b0, 32'h28, 32'h0, 1'b0, dc);
   endtask

   task automatic test_reset_busy();
      int dc;
      wen[0] = 1'b1; addr[0] = 32'h20; dout[0] = 32'hA5A5;
      #1;
      total++;
      if (stall[0] !== 1'b1) begin
         bad++; $display("FAIL rb_stall_t got=%b want=1", stall[0]);
      end
      @(negedge clk); wen[0] = 1'b0; #1;
      total++;
      if (stall[0] !== 1'b1) begin
         bad++; $display("FAIL rb_stall_busy got=%b want=1", stall[0]);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (din[0] !== 32'd0 || stall[0] !== 1'b0 || err[0] !== 1'b0) begin
         bad++; $display("FAIL rb_outputs got=%h/%b/%b want=0/0/0", din[0], stall[0], err[0]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      last_din[0] = 32'd0; last_din[1] = 32'd0;
      access(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, dc);
      access(1, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, dc);
   endtask

   initial begin
      for (int s = 0; s < 2; s++) begin
         ren[s] = 1'b0; wen[s] = 1'b0; addr[s] = 32'd0; dout[s] = 32'd0;
      end
      test_reset();
      test_fill();
      test_write_read();
      test_back_to_back();
      test_reject();
      test_out_of_range();
      test_hold();
      test_scramble();
      test_reset_busy();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
